aibcr3aux_clkdly_calctl: RTL and testbench

- Calibration sequencer for the aux strobe-clock input delay line. It drives the 4-bit delay override code and its enable into the input clock-delay cell feeding the aux strobe-clock tree.
- It sweeps the code, sampling a phase-detector flag at each step, and locks on the first early-to-late transition.
- CSR override takes precedence and bypasses calibration.
- Sits beside the aux clock tree and runs on the aux oscillator clock.

---
 rtl/aibcr3aux_calctl_pkg.sv | 23 ++
 rtl/aibcr3aux_calctl_sync2.sv | 26 ++
 rtl/aibcr3aux_clkdly_calctl.sv | 246 ++++++++++++++++++++++++
 tb/tb_aibcr3aux_clkdly_calctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_calctl_pkg.sv
// Shared state encoding, default parameters and sizing helper for the aux
// strobe-clock delay calibration sequencer.
package aibcr3aux_calctl_pkg;

    localparam int SETTLE_CYC_DEF = 16;
    localparam int NSAMP_DEF      = 8;
    localparam int CODE_W_DEF     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        EVAL   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } cal_state_e;

    // Width able to hold a tally of 0..nsamp early samples.
    function automatic int ones_cnt_w(input int nsamp);
        return (nsamp < 1) ? 1 : $clog2(nsamp + 1);
    endfunction

endpackage

// File: rtl/aibcr3aux_calctl_sync2.sv
// Two-flop synchronizer bringing the asynchronous phase-detector flag into
// the aux oscillator clock domain.
module aibcr3aux_calctl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/aibcr3aux_clkdly_calctl.sv
// Calibration sequencer for the aux strobe-clock input delay line: sweeps the
// delay code, majority-votes the phase detector and locks on the first
// early-to-late transition. Define AIBCR3AUX_CALCTL_TRACK_EN to keep tracking
// the lock code while LOCKED.
module aibcr3aux_clkdly_calctl
    import aibcr3aux_calctl_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int NSAMP      = NSAMP_DEF,
    parameter int CODE_W     = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_start,
    input  logic              pd_early,
    input  logic              csr_dly_ovrden,
    input  logic [CODE_W-1:0] csr_dly_ovrd,
    output logic              dly_ovrden,
    output logic [CODE_W-1:0] dly_ovrd,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              cal_fail,
    output logic [CODE_W-1:0] lock_code
);

    localparam int OW  = ones_cnt_w(NSAMP);
    localparam int SCW = $clog2(SETTLE_CYC + 1);

    localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [OW-1:0]     SAMP_LAST   = OW'(NSAMP - 1);
    localparam logic [OW:0]       NSAMP_V     = (OW + 1)'(NSAMP);
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ZERO   = {CODE_W{1'b0}};

    cal_state_e        state_r;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] lock_code_r;
    logic [SCW-1:0]    settle_cnt_r;
    logic [OW-1:0]     samp_cnt_r;
    logic [OW-1:0]     ones_cnt_r;
    logic              prev_early_r;
    logic              busy_r;
    logic              done_r;
    logic              fail_r;
    logic              en_r;

    logic              pd_sync_s;
    logic [OW-1:0]     ones_next_s;
    logic              early_s;

`ifdef AIBCR3AUX_CALCTL_TRACK_EN
    logic              trk_wait_r;
    logic              trk_early_r;
    logic              trk_late_r;
    logic              unan_early_s;
    logic              unan_late_s;
`endif

    aibcr3aux_calctl_sync2 u_pd_sync (
        .clk (clk),
        .rst (rst),
        .d   (pd_early),
        .q   (pd_sync_s)
    );

    // Running tally including this cycle's sample; strict majority, tie = late.
    always_comb begin
        ones_next_s = ones_cnt_r + OW'(pd_sync_s);
        early_s     = ({ones_cnt_r, 1'b0} > NSAMP_V);
    end

`ifdef AIBCR3AUX_CALCTL_TRACK_EN
    assign unan_early_s = (ones_next_s == OW'(NSAMP));
    assign unan_late_s  = (ones_next_s == {OW{1'b0}});
`endif

    // Calibration FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            code_r       <= CODE_ZERO;
            lock_code_r  <= CODE_ZERO;
            settle_cnt_r <= {SCW{1'b0}};
            samp_cnt_r   <= {OW{1'b0}};
            ones_cnt_r   <= {OW{1'b0}};
            prev_early_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            en_r         <= 1'b0;
`ifdef AIBCR3AUX_CALCTL_TRACK_EN
            trk_wait_r   <= 1'b0;
            trk_early_r  <= 1'b0;
            trk_late_r   <= 1'b0;
`endif
        end else if (csr_dly_ovrden) begin
            // CSR owns the delay cell; drop whatever calibration was doing.
            state_r      <= IDLE;
            code_r       <= CODE_ZERO;
            lock_code_r  <= CODE_ZERO;
            settle_cnt_r <= {SCW{1'b0}};
            samp_cnt_r   <= {OW{1'b0}};
            ones_cnt_r   <= {OW{1'b0}};
            prev_early_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            en_r         <= 1'b0;
`ifdef AIBCR3AUX_CALCTL_TRACK_EN
            trk_wait_r   <= 1'b0;
            trk_early_r  <= 1'b0;
            trk_late_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, LOCKED, FAIL: begin
                    if (cal_start) begin
                        state_r      <= SETTLE;
                        code_r       <= CODE_ZERO;
                        lock_code_r  <= CODE_ZERO;
                        settle_cnt_r <= {SCW{1'b0}};
                        prev_early_r <= 1'b0;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        fail_r       <= 1'b0;
                        en_r         <= 1'b1;
                    end else if (state_r == LOCKED) begin
`ifdef AIBCR3AUX_CALCTL_TRACK_EN
                        if (trk_wait_r) begin
                            if (settle_cnt_r == SETTLE_LAST) begin
                                trk_wait_r   <= 1'b0;
                                settle_cnt_r <= {SCW{1'b0}};
                                samp_cnt_r   <= {OW{1'b0}};
                                ones_cnt_r   <= {OW{1'b0}};
                            end else begin
                                settle_cnt_r <= settle_cnt_r + SCW'(1'b1);
                            end
                        end else if (samp_cnt_r == SAMP_LAST) begin
                            samp_cnt_r <= {OW{1'b0}};
                            ones_cnt_r <= {OW{1'b0}};
                            if (unan_early_s) begin
                                trk_late_r <= 1'b0;
                                if (trk_early_r) begin
                                    trk_early_r <= 1'b0;
                                    if (lock_code_r != CODE_MAX) begin
                                        lock_code_r  <= lock_code_r + CODE_W'(1'b1);
                                        code_r       <= code_r + CODE_W'(1'b1);
                                        trk_wait_r   <= 1'b1;
                                        settle_cnt_r <= {SCW{1'b0}};
                                    end else begin
                                        trk_wait_r   <= 1'b0;
                                    end
                                end else begin
                                    trk_early_r <= 1'b1;
                                end
                            end else if (unan_late_s) begin
                                trk_early_r <= 1'b0;
                                if (trk_late_r) begin
                                    trk_late_r <= 1'b0;
                                    if (lock_code_r != CODE_ZERO) begin
                                        lock_code_r  <= lock_code_r - CODE_W'(1'b1);
                                        code_r       <= code_r - CODE_W'(1'b1);
                                        trk_wait_r   <= 1'b1;
                                        settle_cnt_r <= {SCW{1'b0}};
                                    end else begin
                                        trk_wait_r   <= 1'b0;
                                    end
                                end else begin
                                    trk_late_r <= 1'b1;
                                end
                            end else begin
                                trk_early_r <= 1'b0;
                                trk_late_r  <= 1'b0;
                            end
                        end else begin
                            samp_cnt_r <= samp_cnt_r + OW'(1'b1);
                            ones_cnt_r <= ones_next_s;
                        end
`else
                        state_r <= LOCKED;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= SAMPLE;
                        settle_cnt_r <= {SCW{1'b0}};
                        samp_cnt_r   <= {OW{1'b0}};
                        ones_cnt_r   <= {OW{1'b0}};
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SCW'(1'b1);
                    end
                end
                SAMPLE: begin
                    ones_cnt_r <= ones_next_s;
                    if (samp_cnt_r == SAMP_LAST) begin
                        state_r <= EVAL;
                    end else begin
                        samp_cnt_r <= samp_cnt_r + OW'(1'b1);
                    end
                end
                EVAL: begin
                    // Code 0 has no predecessor, so it can never be the lock point.
                    if ((code_r != CODE_ZERO) && prev_early_r && !early_s) begin
                        state_r     <= LOCKED;
                        lock_code_r <= code_r;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        samp_cnt_r  <= {OW{1'b0}};
                        ones_cnt_r  <= {OW{1'b0}};
`ifdef AIBCR3AUX_CALCTL_TRACK_EN
                        trk_wait_r  <= 1'b0;
                        trk_early_r <= 1'b0;
                        trk_late_r  <= 1'b0;
`endif
                    end else if (code_r == CODE_MAX) begin
                        state_r     <= FAIL;
                        lock_code_r <= CODE_ZERO;
                        busy_r      <= 1'b0;
                        fail_r      <= 1'b1;
                    end else begin
                        state_r      <= SETTLE;
                        code_r       <= code_r + CODE_W'(1'b1);
                        prev_early_r <= early_s;
                        settle_cnt_r <= {SCW{1'b0}};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign dly_ovrden = csr_dly_ovrden | en_r;
    assign dly_ovrd   = csr_dly_ovrden ? csr_dly_ovrd : code_r;
    assign cal_busy   = busy_r;
    assign cal_done   = done_r;
    assign cal_fail   = fail_r;
    assign lock_code  = lock_code_r;

endmodule

// File: tb/tb_aibcr3aux_clkdly_calctl.sv
// Self-checking bench for aibcr3aux_clkdly_calctl: table-driven sweeps with a
// scoreboard queue, plus hand-written abort, reset, restart and LOCKED sequences.
module tb_aibcr3aux_clkdly_calctl;

    localparam int STEP  = 16 + 8 + 1;
    localparam int LIMIT = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       cal_start;
    logic       pd_early;
    logic       csr_dly_ovrden;
    logic [3:0] csr_dly_ovrd;
    logic       dly_ovrden;
    logic [3:0] dly_ovrd;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [3:0] lock_code;

    // Phase-detector model: early while pd_lo <= code < pd_hi, alternating at pd_tie.
    int pd_lo  = 0;
    int pd_hi  = 0;
    int pd_tie = -1;
    bit tgl    = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int lo;
        int hi;
        int tie;
        bit exp_done;
        bit exp_fail;
        int exp_lock;
        int exp_ovrd;
        int exp_cyc;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];

    aibcr3aux_clkdly_calctl dut (
        .clk            (clk),
        .rst            (rst),
        .cal_start      (cal_start),
        .pd_early       (pd_early),
        .csr_dly_ovrden (csr_dly_ovrden),
        .csr_dly_ovrd   (csr_dly_ovrd),
        .dly_ovrden     (dly_ovrden),
        .dly_ovrd       (dly_ovrd),
        .cal_busy       (cal_busy),
        .cal_done       (cal_done),
        .cal_fail       (cal_fail),
        .lock_code      (lock_code)
    );

    always #5 clk = ~clk;

    initial begin
        int code;
        pd_early = 1'b0;
        forever begin
            @(negedge clk);
            tgl  = ~tgl;
            code = int'(dly_ovrd);
            if (code >= pd_lo && code < pd_hi) pd_early = 1'b1;
            else if (code == pd_tie)           pd_early = tgl;
            else                               pd_early = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1 cal_start = 1'b0;
    endtask

    task automatic wait_code(input int c);
        int n = 0;
        while (int'(dly_ovrd) != c && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("reach_code_%0d", c), 32'(dly_ovrd), 32'(c));
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(cal_done || cal_fail) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_row(input vec_t v, input int idx);
        int   n;
        vec_t e;
        @(negedge clk);
        pd_lo  = v.lo;
        pd_hi  = v.hi;
        pd_tie = v.tie;
        sb_q.push_back(v);
        pulse_start();
        check($sformatf("row%0d_busy_start", idx), 32'(cal_busy), 32'd1);
        wait_end(n);
        e = sb_q.pop_front();
        check($sformatf("row%0d_done", idx),    32'(cal_done),   32'(e.exp_done));
        check($sformatf("row%0d_fail", idx),    32'(cal_fail),   32'(e.exp_fail));
        check($sformatf("row%0d_lock", idx),    32'(lock_code),  32'(e.exp_lock));
        check($sformatf("row%0d_ovrd", idx),    32'(dly_ovrd),   32'(e.exp_ovrd));
        check($sformatf("row%0d_ovrden", idx),  32'(dly_ovrden), 32'd1);
        check($sformatf("row%0d_busy_end", idx), 32'(cal_busy),  32'd0);
        check($sformatf("row%0d_cycles", idx),  32'(n),          32'(e.exp_cyc));
    endtask

    initial begin
        int  n;
        bit  done_held;

        vecs[0] = '{0, 6, -1, 1'b1, 1'b0, 6, 6, 7 * STEP};
        vecs[1] = '{0, 16, -1, 1'b0, 1'b1, 0, 15, 16 * STEP};
        vecs[2] = '{0, 3, 3, 1'b1, 1'b0, 3, 3, 4 * STEP};
        vecs[3] = '{0, 0, -1, 1'b0, 1'b1, 0, 15, 16 * STEP};
        vecs[4] = '{0, 1, -1, 1'b1, 1'b0, 1, 1, 2 * STEP};
        vecs[5] = '{0, 15, -1, 1'b1, 1'b0, 15, 15, 16 * STEP};
        vecs[6] = '{1, 2, -1, 1'b1, 1'b0, 2, 2, 3 * STEP};
        vecs[7] = '{3, 5, -1, 1'b1, 1'b0, 5, 5, 6 * STEP};

        rst            = 1'b1;
        cal_start      = 1'b0;
        csr_dly_ovrden = 1'b0;
        csr_dly_ovrd   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovrden", 32'(dly_ovrden), 32'd0);
        check("rst_ovrd",   32'(dly_ovrd),   32'd0);
        check("rst_busy",   32'(cal_busy),   32'd0);
        check("rst_done",   32'(cal_done),   32'd0);
        check("rst_fail",   32'(cal_fail),   32'd0);
        check("rst_lock",   32'(lock_code),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_row(vecs[i], i);

        // CSR abort during SETTLE at code 4, then start ignored while CSR set.
        @(negedge clk);
        pd_lo = 0; pd_hi = 16; pd_tie = -1;
        pulse_start();
        wait_code(4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        csr_dly_ovrden = 1'b1;
        csr_dly_ovrd   = 4'd9;
        #1;
        check("csr_ovrd_same_cycle",   32'(dly_ovrd),   32'd9);
        check("csr_ovrden_same_cycle", 32'(dly_ovrden), 32'd1);
        @(posedge clk);
        #1;
        check("csr_abort_busy", 32'(cal_busy),  32'd0);
        check("csr_abort_done", 32'(cal_done),  32'd0);
        check("csr_abort_fail", 32'(cal_fail),  32'd0);
        check("csr_abort_lock", 32'(lock_code), 32'd0);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check("csr_start_ignored", 32'(cal_busy), 32'd0);
        check("csr_ovrd_hold",     32'(dly_ovrd), 32'd9);
        @(negedge clk);
        csr_dly_ovrden = 1'b0;
        #1;
        check("csr_release_ovrden", 32'(dly_ovrden), 32'd0);
        check("csr_release_ovrd",   32'(dly_ovrd),   32'd0);

        // Reset asserted mid-sweep at code 5.
        pulse_start();
        wait_code(5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ovrden", 32'(dly_ovrden), 32'd0);
        check("midrst_ovrd",   32'(dly_ovrd),   32'd0);
        check("midrst_busy",   32'(cal_busy),   32'd0);
        check("midrst_done",   32'(cal_done),   32'd0);
        check("midrst_fail",   32'(cal_fail),   32'd0);
        check("midrst_lock",   32'(lock_code),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_idle", 32'(cal_busy), 32'd0);

        // Restart from LOCKED, then a start during busy must be ignored.
        run_row(vecs[0], 8);
        pulse_start();
        check("restart_done_clr", 32'(cal_done),  32'd0);
        check("restart_busy",     32'(cal_busy),  32'd1);
        check("restart_code0",    32'(dly_ovrd),  32'd0);
        check("restart_lock_clr", 32'(lock_code), 32'd0);
        wait_code(2);
        pulse_start();
        check("busy_start_code", 32'(dly_ovrd), 32'd2);
        check("busy_start_busy", 32'(cal_busy), 32'd1);
        wait_end(n);
        check("busy_start_done", 32'(cal_done),  32'd1);
        check("busy_start_lock", 32'(lock_code), 32'd6);

        // Hold strobe early while LOCKED at 6.
        @(negedge clk);
        pd_lo = 0; pd_hi = 16; pd_tie = -1;
        done_held = 1'b1;
`ifdef AIBCR3AUX_CALCTL_TRACK_EN
        n = 0;
        while (lock_code != 4'd7 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!cal_done) done_held = 1'b0;
        end
        check("track_lock", 32'(lock_code), 32'd7);
        check("track_ovrd", 32'(dly_ovrd),  32'd7);
        check("track_done", 32'(done_held), 32'd1);
`else
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (!cal_done) done_held = 1'b0;
        end
        check("static_lock", 32'(lock_code), 32'd6);
        check("static_ovrd", 32'(dly_ovrd),  32'd6);
        check("static_done", 32'(done_held), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
